// File: rtl/minesweeper_board_arbiter_if.sv
// rtl/minesweeper_board_arbiter_if.sv - processor, display, board RAM and clear signals of the board arbiter
interface minesweeper_board_arbiter_if;
  logic       proc_req;
  logic       proc_we;
  logic [7:0] proc_addr;
  logic [0:5] proc_wdata;
  logic [0:5] proc_rdata;
  logic       proc_ack;
  logic       rstBoard;
  logic       vga_req;
  logic [7:0] vga_addr;
  logic [0:5] vga_rdata;
  logic       vga_valid;
  logic [7:0] ram_addr;
  logic       ram_we;
  logic [0:5] ram_wdata;
  logic [0:5] ram_rdata;
  logic       busy;

  modport slave (
    input  proc_req, proc_we, proc_addr, proc_wdata, rstBoard, vga_req, vga_addr, ram_rdata,
    output proc_rdata, proc_ack, vga_rdata, vga_valid, ram_addr, ram_we, ram_wdata, busy
  );

  modport master (
    output proc_req, proc_we, proc_addr, proc_wdata, rstBoard, vga_req, vga_addr, ram_rdata,
    input  proc_rdata, proc_ack, vga_rdata, vga_valid, ram_addr, ram_we, ram_wdata, busy
  );
endinterface

// File: rtl/minesweeper_board_arbiter.sv
// rtl/minesweeper_board_arbiter.sv - arbitrates processor and display access to the board RAM, with whole-board clear
module minesweeper_board_arbiter #(
  parameter logic [0:5]  CLEAR_VAL  = 6'b000000,
  parameter int unsigned STARVE_MAX = 3
) (
  input logic                        clk,
  input logic                        reset,
  minesweeper_board_arbiter_if.slave bus
);

  localparam int unsigned      CNT_W      = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       clr_cnt_q, clr_cnt_d;
  logic [CNT_W-1:0] deny_q, deny_d;
  logic             p_s1_q, p_s1_d, p_ack_q, p_ack_d;
  logic             v_s1_q, v_s1_d, v_ack_q, v_ack_d;
  logic [7:0]       ram_addr_q, ram_addr_d;
  logic             ram_we_q, ram_we_d;
  logic [0:5]       ram_wdata_q, ram_wdata_d;

  logic p_elig, v_elig, v_wins, grant_p, grant_v, in_flight;

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    deny_d      = deny_q;
    p_s1_d      = 1'b0;
    v_s1_d      = 1'b0;
    p_ack_d     = p_s1_q;
    v_ack_d     = v_s1_q;
    ram_addr_d  = '0;
    ram_we_d    = 1'b0;
    ram_wdata_d = '0;
    grant_p     = 1'b0;
    grant_v     = 1'b0;
    // A requester stays ineligible from its grant through its ack cycle.
    in_flight   = p_s1_q | p_ack_q | v_s1_q | v_ack_q;
    p_elig      = bus.proc_req & ~p_s1_q & ~p_ack_q;
    v_elig      = bus.vga_req & ~v_s1_q & ~v_ack_q;
    v_wins      = v_elig & (~p_elig | (deny_q == STARVE_LIM));

    case (state_q)
      SERVE: begin
        if (bus.rstBoard) begin
          state_d = DRAIN;
        end else if (v_wins) begin
          grant_v = 1'b1;
          deny_d  = '0;
        end else if (p_elig) begin
          grant_p = 1'b1;
          if (v_elig && (deny_q != STARVE_LIM)) deny_d = deny_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (!in_flight) begin
          state_d     = CLEAR;
          clr_cnt_d   = '0;
          ram_we_d    = 1'b1;
          ram_wdata_d = CLEAR_VAL;
        end
      end
      CLEAR: begin
        // clr_cnt tracks the address currently on the RAM bus.
        if (bus.rstBoard) begin
          clr_cnt_d = '0;
        end else if (clr_cnt_q == 8'hFF) begin
          state_d   = SERVE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 8'd1;
        end
        if (state_d == CLEAR) begin
          ram_addr_d  = clr_cnt_d;
          ram_we_d    = 1'b1;
          ram_wdata_d = CLEAR_VAL;
        end
      end
      default: state_d = SERVE;
    endcase

    if (grant_p) begin
      p_s1_d      = 1'b1;
      ram_addr_d  = bus.proc_addr;
      ram_we_d    = bus.proc_we;
      ram_wdata_d = bus.proc_we ? bus.proc_wdata : '0;
    end
    if (grant_v) begin
      v_s1_d     = 1'b1;
      ram_addr_d = bus.vga_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= SERVE;
      clr_cnt_q   <= '0;
      deny_q      <= '0;
      p_s1_q      <= 1'b0;
      p_ack_q     <= 1'b0;
      v_s1_q      <= 1'b0;
      v_ack_q     <= 1'b0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      deny_q      <= deny_d;
      p_s1_q      <= p_s1_d;
      p_ack_q     <= p_ack_d;
      v_s1_q      <= v_s1_d;
      v_ack_q     <= v_ack_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_we     = ram_we_q;
  assign bus.ram_wdata  = ram_wdata_q;
  assign bus.proc_ack   = p_ack_q;
  assign bus.vga_valid  = v_ack_q;
  assign bus.proc_rdata = p_ack_q ? bus.ram_rdata : '0;
  assign bus.vga_rdata  = v_ack_q ? bus.ram_rdata : '0;
  assign bus.busy       = (state_q != SERVE);

endmodule

// File: tb/tb_minesweeper_board_arbiter.sv
// tb/tb_minesweeper_board_arbiter.sv - randomized and directed self-checking bench for minesweeper_board_arbiter
module tb_minesweeper_board_arbiter;

  localparam int         STARVE = 3;
  localparam logic [0:5] CLRV   = 6'b000000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  minesweeper_board_arbiter_if bus ();

  minesweeper_board_arbiter #(
    .CLEAR_VAL (CLRV),
    .STARVE_MAX(STARVE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Board RAM: synchronous read, data one cycle after the address.
  logic [0:5] mem [256];
  logic       load_en;
  logic [7:0] load_addr;
  logic [0:5] load_data;
  always @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
    else if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a timeline of expected events, four cycles deep.
  logic [0:5] golden [256];
  bit         e_pack [4], e_vval [4], e_prchk [4], e_vrchk [4], e_acc [4], e_we [4], e_busy [4];
  logic [7:0] e_addr [4];
  logic [0:5] e_wd [4], e_prd [4], e_vrd [4];
  int         cyc     = 0;
  int         phase   = 0;
  int         clr     = 0;
  int         deny    = 0;
  int         p_until = -10;
  int         v_until = -10;

  task automatic clear_slot(input int s);
    e_pack[s] = 0; e_vval[s] = 0; e_prchk[s] = 0; e_vrchk[s] = 0;
    e_acc[s]  = 0; e_we[s]   = 0; e_busy[s]  = 0;
  endtask

  task automatic sched_ram(input int s, input bit we, input logic [7:0] a, input logic [0:5] d);
    e_acc[s] = 1; e_we[s] = we; e_addr[s] = a; e_wd[s] = d;
    if (we) golden[a] = d;
  endtask

  task automatic model_step();
    int n1, n2;
    bit pe, ve, infl;
    n1 = (cyc + 1) % 4;
    n2 = (cyc + 2) % 4;
    clear_slot(n2);
    if (!reset) begin
      clear_slot(n1);
      phase = 0; clr = 0; deny = 0; p_until = -10; v_until = -10;
    end else begin
      infl = (p_until >= cyc) || (v_until >= cyc);
      if (phase == 0) begin
        if (bus.rstBoard) begin
          phase = 1;
        end else begin
          pe = bus.proc_req && (p_until < cyc);
          ve = bus.vga_req && (v_until < cyc);
          if (ve && (!pe || deny == STARVE)) begin
            e_vval[n2] = 1; e_vrchk[n2] = 1; e_vrd[n2] = golden[bus.vga_addr];
            sched_ram(n1, 0, bus.vga_addr, 6'b0);
            v_until = cyc + 2;
            deny = 0;
          end else if (pe) begin
            e_pack[n2] = 1; e_prchk[n2] = !bus.proc_we; e_prd[n2] = golden[bus.proc_addr];
            sched_ram(n1, bus.proc_we, bus.proc_addr, bus.proc_we ? bus.proc_wdata : 6'b0);
            p_until = cyc + 2;
            if (ve && deny < STARVE) deny++;
          end
        end
      end else if (phase == 1) begin
        if (!infl) begin
          phase = 2; clr = 0;
          sched_ram(n1, 1, 8'h00, CLRV);
        end
      end else begin
        if (bus.rstBoard) clr = 0;
        else if (clr == 255) phase = 0;
        else clr++;
        if (phase == 2) sched_ram(n1, 1, 8'(clr), CLRV);
      end
    end
    e_busy[n1] = (phase != 0);
    cyc++;
  endtask

  task automatic check_cycle();
    int s;
    s = cyc % 4;
    chk("proc_ack", bus.proc_ack, e_pack[s]);
    chk("vga_valid", bus.vga_valid, e_vval[s]);
    chk("busy", bus.busy, e_busy[s]);
    chk("ram_we", bus.ram_we, e_we[s]);
    if (e_acc[s]) chk("ram_addr", bus.ram_addr, e_addr[s]);
    if (e_we[s]) chk("ram_wdata", bus.ram_wdata, e_wd[s]);
    if (e_prchk[s]) chk("proc_rdata", bus.proc_rdata, e_prd[s]);
    if (e_vrchk[s]) chk("vga_rdata", bus.vga_rdata, e_vrd[s]);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic wait_proc_ack(input string nm);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.proc_ack && n < 20);
    chk(nm, bus.proc_ack, 1);
  endtask

  task automatic wait_clear_addr(input logic [7:0] a, input string nm);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(bus.ram_we && bus.ram_addr == a) && n < 400);
    chk(nm, bus.ram_addr, a);
  endtask

  // Counts clear writes starting from address `first`, then checks busy falls right after 8'hFF.
  task automatic count_clear(input int first, input string nm);
    int w, guard;
    w = first; guard = 0;
    while (w < 256 && guard < 400) begin
      tick();
      guard++;
      if (bus.ram_we) begin
        chk({nm, "_addr"}, bus.ram_addr, 32'(w));
        chk({nm, "_data"}, bus.ram_wdata, CLRV);
        chk({nm, "_busy"}, bus.busy, 1);
        w++;
      end
    end
    chk({nm, "_writes"}, 32'(w - first), 32'(256 - first));
    tick();
    chk({nm, "_busy_low"}, bus.busy, 0);
  endtask

  initial begin
    int last_p, run, vcount;
    reset = 1'b0;
    load_en = 1'b1; load_addr = '0; load_data = '0;
    bus.proc_req = 0; bus.proc_we = 0; bus.proc_addr = '0; bus.proc_wdata = '0;
    bus.vga_req = 0; bus.vga_addr = '0; bus.rstBoard = 0;

    for (int i = 0; i < 256; i++) begin
      load_addr = 8'(i);
      load_data = (i == 8'h12) ? 6'b010011 : 6'($urandom);
      golden[i] = load_data;
      tick();
    end
    tick();
    load_en = 1'b0;
    chk("rst_proc_ack", bus.proc_ack, 0);
    chk("rst_vga_valid", bus.vga_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ram_we", bus.ram_we, 0);
    chk("rst_ram_addr", bus.ram_addr, 0);
    chk("rst_proc_rdata", bus.proc_rdata, 0);
    reset = 1'b1;
    tick();

    // Read of 8'h12: address at N+1, ack with data at N+2.
    bus.proc_req = 1; bus.proc_we = 0; bus.proc_addr = 8'h12;
    tick();
    chk("rd12_ram_addr", bus.ram_addr, 8'h12);
    chk("rd12_ram_we", bus.ram_we, 0);
    chk("rd12_no_early_ack", bus.proc_ack, 0);
    tick();
    chk("rd12_ack", bus.proc_ack, 1);
    chk("rd12_data", bus.proc_rdata, 6'b010011);
    bus.proc_req = 0;
    tick();

    // Write then read back 8'hFF.
    bus.proc_req = 1; bus.proc_we = 1; bus.proc_addr = 8'hFF; bus.proc_wdata = 6'b111111;
    wait_proc_ack("wrFF_ack");
    bus.proc_we = 0;
    wait_proc_ack("rdFF_ack");
    chk("rdFF_data", bus.proc_rdata, 6'b111111);
    bus.proc_req = 0;
    tick();

    // Board clear with a read in flight.
    bus.proc_req = 1; bus.proc_we = 0; bus.proc_addr = 8'h05;
    tick();
    bus.rstBoard = 1;
    tick();
    chk("drain_ack", bus.proc_ack, 1);
    chk("drain_busy", bus.busy, 1);
    bus.rstBoard = 0; bus.proc_req = 0;
    count_clear(0, "clr1");

    // Clear restarted at 8'h80.
    bus.rstBoard = 1;
    tick();
    bus.rstBoard = 0;
    wait_clear_addr(8'h80, "clr2_reach80");
    bus.rstBoard = 1;
    tick();
    bus.rstBoard = 0;
    chk("clr2_restart_addr", bus.ram_addr, 8'h00);
    chk("clr2_restart_we", bus.ram_we, 1);
    count_clear(1, "clr2");

    // Reset in the middle of a clear.
    bus.rstBoard = 1;
    tick();
    bus.rstBoard = 0;
    wait_clear_addr(8'h40, "clr3_reach40");
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("abort_ram_we", bus.ram_we, 0);
    chk("abort_busy", bus.busy, 0);
    tick();
    tick();
    chk("abort_stays_idle", bus.ram_we, 0);
    bus.proc_req = 1; bus.proc_we = 0; bus.proc_addr = 8'h41;
    wait_proc_ack("abort_serve_ack");
    bus.proc_req = 0;
    tick();

    // Both requesters continuously busy.
    last_p = -100; run = 0; vcount = 0;
    bus.proc_req = 1; bus.vga_req = 1;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (bus.proc_ack) begin
        chk("proc_ack_spacing", 32'((cyc - last_p) >= 3), 1);
        last_p = cyc;
        run++;
        chk("vga_starve_run", 32'(run <= STARVE), 1);
        bus.proc_addr = 8'($urandom_range(0, 15));
      end
      if (bus.vga_valid) begin
        run = 0;
        vcount++;
        bus.vga_addr = 8'($urandom_range(0, 15));
      end
    end
    chk("vga_grants_seen", 32'(vcount >= 10), 1);
    bus.proc_req = 0; bus.vga_req = 0;
    tick();
    tick();

    // Randomized traffic against the model.
    for (int k = 0; k < 5000; k++) begin
      if (!bus.proc_req || bus.proc_ack) begin
        bus.proc_req   = ($urandom_range(0, 99) < 60);
        bus.proc_we    = 1'($urandom_range(0, 1));
        bus.proc_addr  = 8'($urandom_range(0, 7));
        bus.proc_wdata = 6'($urandom);
      end
      if (!bus.vga_req || bus.vga_valid) begin
        bus.vga_req  = ($urandom_range(0, 99) < 60);
        bus.vga_addr = 8'($urandom_range(0, 7));
      end
      bus.rstBoard = ($urandom_range(0, 399) == 0);
      reset        = ($urandom_range(0, 1499) != 0);
      tick();
    end
    reset = 1'b1; bus.rstBoard = 0; bus.proc_req = 0; bus.vga_req = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/minesweeper_board_arbiter.md
MINESWEEPER_BOARD_ARBITER -- requirements
Module: minesweeper_board_arbiter

Interface
REQ-001 SHALL have parameter CLEAR_VAL, default 6'b000000, cell value written during board clear.
REQ-002 SHALL have parameter STARVE_MAX, default 3, consecutive VGA denials before VGA is forced to win.
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port proc_req  input  1  processor access request, held high until proc_ack.
REQ-006 SHALL have port proc_we  input  1  processor write (1) / read (0), valid with proc_req.
REQ-007 SHALL have port proc_addr  input  8  processor cell address.
REQ-008 SHALL have port proc_wdata  input  [0:5]  processor write data.
REQ-009 SHALL have port proc_rdata  output  [0:5]  processor read data, valid when proc_ack=1.
REQ-010 SHALL have port proc_ack  output  1  one-cycle completion pulse for a processor access.
REQ-011 SHALL have port rstBoard  input  1  board clear request, level-sampled.
REQ-012 SHALL have port vga_req  input  1  display read request, held until vga_valid.
REQ-013 SHALL have port vga_addr  input  8  display cell address.
REQ-014 SHALL have port vga_rdata  output  [0:5]  display read data, valid when vga_valid=1.
REQ-015 SHALL have port vga_valid  output  1  one-cycle completion pulse for a display read.
REQ-016 SHALL have port ram_addr  output  8  board RAM address (registered).
REQ-017 SHALL have port ram_we  output  1  board RAM write enable (registered).
REQ-018 SHALL have port ram_wdata  output  [0:5]  board RAM write data (registered).
REQ-019 SHALL have port ram_rdata  input  [0:5]  board RAM read data, one cycle after ram_addr.
REQ-020 SHALL have port busy  output  1  high while a board clear is pending or running.

Function
REQ-021 SHALL implement FSM states SERVE, DRAIN, CLEAR; reset state SERVE.
REQ-022 SHALL, in SERVE, sample requests in cycle N, drive ram_addr/ram_we/ram_wdata in N+1, and pulse ack/valid with data in N+2 (fixed 2-cycle latency, reads and writes).
REQ-023 SHALL treat a requester with an access in flight as ineligible until its ack/valid cycle; an eligible requester may be granted the cycle after its previous ack.
REQ-024 SHALL grant at most one access per cycle; proc and vga accesses may be in flight simultaneously, one each.
REQ-025 SHALL give priority to proc when both eligible, except that VGA wins when its denial counter equals STARVE_MAX.
REQ-026 SHALL increment the denial counter each cycle an eligible vga_req loses, saturate at STARVE_MAX, and clear it on VGA grant.
REQ-027 SHALL force vga_we low; VGA accesses are reads only.
REQ-028 SHALL, on rstBoard=1 in SERVE, assert busy next cycle, stop new grants, and enter DRAIN.
REQ-029 SHALL leave DRAIN for CLEAR in the first cycle with no access in flight; in-flight accesses complete normally.
REQ-030 SHALL, in CLEAR, write CLEAR_VAL to addresses 0..255 ascending, one per cycle, ram_we=1, no acks.
REQ-031 SHALL restart the clear at address 0 if rstBoard=1 is sampled during CLEAR.
REQ-032 SHALL return to SERVE and deassert busy the cycle after address 255 is written; pending requests are then arbitrated normally.
REQ-033 SHALL hold ram_we=0 in any cycle with no granted write and no clear write.
REQ-034 SHALL ignore proc_req/vga_req changes during DRAIN/CLEAR other than holding them pending.

Reset
REQ-035 SHALL, when reset=0 at a clock edge, set state SERVE, all outputs 0, clear address counter 0, denial counter 0, in-flight flags 0.
REQ-036 SHALL abort a clear or in-flight access on reset with no further RAM writes and no acks.

Verification
REQ-037 SHALL cover: proc read addr 8'h12 (RAM holds 6'b010011) -> ram_addr=8'h12 at N+1, proc_ack=1 and proc_rdata=6'b010011 at N+2.
REQ-038 SHALL cover: proc and vga requesting continuously -> VGA granted at least once every STARVE_MAX+1=4 grants, never two proc grants for same access.
REQ-039 SHALL cover: rstBoard pulse with proc read in flight -> proc_ack delivered, then 256 writes of 6'b000000 to 0..255, busy high throughout, low one cycle after write to 8'hFF.
REQ-040 SHALL cover: rstBoard reasserted at clear address 8'h80 -> next write at address 8'h00, total 256 further writes.
REQ-041 SHALL cover: reset=0 at clear address 8'h40 -> ram_we=0 next cycle, busy=0, state SERVE.
REQ-042 SHALL cover: proc write addr 8'hFF data 6'b111111 then read same -> read returns 6'b111111.
